chrono_counter: RTL and testbench

CHRONO_COUNTER -- requirements
Module: chrono_counter

---
 rtl/chrono_pkg.sv | 49 ++++
 rtl/chrono_counter_bcd_digit.sv | 43 ++++
 rtl/chrono_counter.sv | 160 ++++++++++++++++
 tb/tb_chrono_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared packing, digit limits and zero-time constants for the chrono counter.
// The time word packs BCD digits {hd,hu,md,mu,sd,su,ds,cs} from MSB to LSB.
package chrono_pkg;
   localparam int TIME_W = 28;

   localparam int CS_LSB = 0;
   localparam int CS_W   = 4;
   localparam int DS_LSB = 4;
   localparam int DS_W   = 4;
   localparam int SU_LSB = 8;
   localparam int SU_W   = 4;
   localparam int SD_LSB = 12;
   localparam int SD_W   = 3;
   localparam int MU_LSB = 15;
   localparam int MU_W   = 4;
   localparam int MD_LSB = 19;
   localparam int MD_W   = 3;
   localparam int HU_LSB = 22;
   localparam int HU_W   = 4;
   localparam int HD_LSB = 26;
   localparam int HD_W   = 2;

   localparam int DEC_MAX = 9;
   localparam int SEX_MAX = 5;

   typedef struct packed {
      logic [HD_W-1:0] hd;
      logic [HU_W-1:0] hu;
      logic [MD_W-1:0] md;
      logic [MU_W-1:0] mu;
      logic [SD_W-1:0] sd;
      logic [SU_W-1:0] su;
      logic [DS_W-1:0] ds;
      logic [CS_W-1:0] cs;
   } chrono_time_t;

   // Hours limits kept as packed BCD {hd,hu}.
   localparam logic [5:0] HR_MAX_24 = 6'h23;
   localparam logic [5:0] HR_MIN_24 = 6'h00;
   localparam logic [5:0] HR_MAX_12 = 6'h12;
   localparam logic [5:0] HR_MIN_12 = 6'h01;

   localparam chrono_time_t ZERO_24H = chrono_time_t'({2'd0, 4'd0, 22'd0});
   localparam chrono_time_t ZERO_12H = chrono_time_t'({2'd1, 4'd2, 22'd0});

   function automatic chrono_time_t zero_time(input logic mode_24h);
      return mode_24h ? ZERO_24H : ZERO_12H;
   endfunction
endpackage

// File: rtl/chrono_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with combinational carry/borrow for chaining.
// Load has priority over inc, inc over dec; the new value appears one edge later.
module bcd_digit #(
   parameter int MAX = 9,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] q,
   output logic         carry,
   output logic         borrow
);
   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] q_d, q_q;

   assign carry  = inc && (q_q == MAX_V);
   assign borrow = dec && (q_q == '0);
   assign q      = q_q;

   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = ld_val;
      end else if (inc) begin
         q_d = carry ? '0 : q_q + 1'b1;
      end else if (dec) begin
         q_d = borrow ? MAX_V : q_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end
endmodule

// File: rtl/chrono_counter.sv
// BCD up/down chronometer (hh:mm:ss.cc) with preset load, lap freeze and event pulses.
// time_q shows a tick or load one cycle after its edge; wrap/done/load_err align with it.
module chrono_counter
   import chrono_pkg::*;
#(
   parameter int TICK_DIV = 1,
   parameter int MODE_24H = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        dir,
   input  logic        load,
   input  logic [27:0] preset,
   input  logic        lap_hold,
   output logic [27:0] time_q,
   output logic        wrap,
   output logic        done,
   output logic        load_err
);
   localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
   localparam chrono_time_t    ZERO      = zero_time(MODE_24H != 0);
   localparam chrono_time_t    ZERO_P1   = chrono_time_t'(TIME_W'(ZERO) + TIME_W'(1));
   localparam logic [5:0]      HR_MAX    = (MODE_24H != 0) ? HR_MAX_24 : HR_MAX_12;
   localparam logic [5:0]      HR_MIN    = (MODE_24H != 0) ? HR_MIN_24 : HR_MIN_12;

   chrono_time_t    pre, cur, lap_d, lap_q, time_d, time_q_q;
   logic [PW-1:0]   presc_d, presc_q;
   logic [5:0]      pre_hrs;
   logic            legal, ld, tick, tick_up, tick_dn, at_zero;
   logic [HD_W-1:0] hd_d, hd_q;
   logic [HU_W-1:0] hu_d, hu_q;
   logic            hr_inc, hr_dec, wrap_ev, done_ev, err_ev;
   logic [2:0]      ev_q;
   logic            wrap_q, done_q, load_err_q, lap_hold_q, lap_rise;
   logic [CS_W-1:0] cs_q;
   logic [DS_W-1:0] ds_q;
   logic [SU_W-1:0] su_q;
   logic [SD_W-1:0] sd_q;
   logic [MU_W-1:0] mu_q;
   logic [MD_W-1:0] md_q;
   logic            cs_c, cs_b, ds_c, ds_b, su_c, su_b, sd_c, sd_b, mu_c, mu_b;

   assign pre = '{hd: preset[HD_LSB +: HD_W], hu: preset[HU_LSB +: HU_W],
                  md: preset[MD_LSB +: MD_W], mu: preset[MU_LSB +: MU_W],
                  sd: preset[SD_LSB +: SD_W], su: preset[SU_LSB +: SU_W],
                  ds: preset[DS_LSB +: DS_W], cs: preset[CS_LSB +: CS_W]};
   assign pre_hrs = 6'(pre.hd) * 6'd10 + 6'(pre.hu);

   always_comb begin
      legal = (pre.cs <= CS_W'(DEC_MAX)) && (pre.ds <= DS_W'(DEC_MAX)) &&
              (pre.su <= SU_W'(DEC_MAX)) && (pre.sd <= SD_W'(SEX_MAX)) &&
              (pre.mu <= MU_W'(DEC_MAX)) && (pre.md <= MD_W'(SEX_MAX)) &&
              (pre.hu <= HU_W'(DEC_MAX));
      if (MODE_24H != 0) begin
         legal = legal && (pre_hrs <= 6'd23);
      end else begin
         legal = legal && (pre_hrs >= 6'd1) && (pre_hrs <= 6'd12);
      end
   end

   // Any load, legal or not, swallows a coincident tick.
   assign ld      = load && legal;
   assign err_ev  = load && !legal;
   assign tick    = run && !load && (presc_q == PRESC_MAX);
   assign at_zero = (cur == ZERO);
   assign tick_up = tick && !dir;
   assign tick_dn = tick && dir && !at_zero;
   assign done_ev = tick_dn && (cur == ZERO_P1);

   always_comb begin
      presc_d = presc_q;
      if (load || tick) begin
         presc_d = '0;
      end else if (run) begin
         presc_d = presc_q + 1'b1;
      end
   end

   bcd_digit #(.MAX(DEC_MAX), .W(CS_W)) u_cs (.clk(clk), .rst_n(rst_n), .inc(tick_up), .dec(tick_dn),
      .ld(ld), .ld_val(pre.cs), .q(cs_q), .carry(cs_c), .borrow(cs_b));
   bcd_digit #(.MAX(DEC_MAX), .W(DS_W)) u_ds (.clk(clk), .rst_n(rst_n), .inc(cs_c), .dec(cs_b),
      .ld(ld), .ld_val(pre.ds), .q(ds_q), .carry(ds_c), .borrow(ds_b));
   bcd_digit #(.MAX(DEC_MAX), .W(SU_W)) u_su (.clk(clk), .rst_n(rst_n), .inc(ds_c), .dec(ds_b),
      .ld(ld), .ld_val(pre.su), .q(su_q), .carry(su_c), .borrow(su_b));
   bcd_digit #(.MAX(SEX_MAX), .W(SD_W)) u_sd (.clk(clk), .rst_n(rst_n), .inc(su_c), .dec(su_b),
      .ld(ld), .ld_val(pre.sd), .q(sd_q), .carry(sd_c), .borrow(sd_b));
   bcd_digit #(.MAX(DEC_MAX), .W(MU_W)) u_mu (.clk(clk), .rst_n(rst_n), .inc(sd_c), .dec(sd_b),
      .ld(ld), .ld_val(pre.mu), .q(mu_q), .carry(mu_c), .borrow(mu_b));
   bcd_digit #(.MAX(SEX_MAX), .W(MD_W)) u_md (.clk(clk), .rst_n(rst_n), .inc(mu_c), .dec(mu_b),
      .ld(ld), .ld_val(pre.md), .q(md_q), .carry(hr_inc), .borrow(hr_dec));

   assign cur = '{hd: hd_q, hu: hu_q, md: md_q, mu: mu_q, sd: sd_q, su: su_q, ds: ds_q, cs: cs_q};

   // Hours wrap between HR_MAX and HR_MIN; a carry out of HR_MAX is the full-time rollover.
   always_comb begin
      hd_d    = hd_q;
      hu_d    = hu_q;
      wrap_ev = 1'b0;
      if (ld) begin
         hd_d = pre.hd;
         hu_d = pre.hu;
      end else if (hr_inc) begin
         if ({hd_q, hu_q} == HR_MAX) begin
            {hd_d, hu_d} = HR_MIN;
            wrap_ev      = 1'b1;
         end else if (hu_q == HU_W'(DEC_MAX)) begin
            hd_d = hd_q + 1'b1;
            hu_d = '0;
         end else begin
            hu_d = hu_q + 1'b1;
         end
      end else if (hr_dec) begin
         if ({hd_q, hu_q} == HR_MIN) begin
            {hd_d, hu_d} = HR_MAX;
         end else if (hu_q == '0) begin
            hd_d = hd_q - 1'b1;
            hu_d = HU_W'(DEC_MAX);
         end else begin
            hu_d = hu_q - 1'b1;
         end
      end
   end

   assign lap_rise = lap_hold && !lap_hold_q;
   assign lap_d    = lap_rise ? cur : lap_q;
   assign time_d   = (lap_hold && !lap_rise) ? lap_q : cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         hd_q       <= ZERO.hd;
         hu_q       <= ZERO.hu;
         lap_q      <= ZERO;
         lap_hold_q <= 1'b0;
         time_q_q   <= ZERO;
         ev_q       <= '0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         hd_q       <= hd_d;
         hu_q       <= hu_d;
         lap_q      <= lap_d;
         lap_hold_q <= lap_hold;
         time_q_q   <= time_d;
         ev_q       <= {wrap_ev, done_ev, err_ev};
         wrap_q     <= ev_q[2];
         done_q     <= ev_q[1];
         load_err_q <= ev_q[0];
      end
   end

   assign time_q   = time_q_q;
   assign wrap     = wrap_q;
   assign done     = done_q;
   assign load_err = load_err_q;
endmodule

// File: tb/tb_chrono_counter.sv
// Self-checking bench: three chrono_counter configs driven from a vector table and a
// few hand sequences; expectations go through a scoreboard queue.
module tb_chrono_counter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        run_s [3];
   logic        dir_s [3];
   logic        load_s[3];
   logic        lap_s [3];
   logic [27:0] pre_s [3];
   logic [27:0] tq    [3];
   logic        wrap_s[3];
   logic        done_s[3];
   logic        err_s [3];

   chrono_counter #(.TICK_DIV(1), .MODE_24H(1)) u_d24 (
      .clk(clk), .rst_n(rst_n), .run(run_s[0]), .dir(dir_s[0]), .load(load_s[0]),
      .preset(pre_s[0]), .lap_hold(lap_s[0]), .time_q(tq[0]), .wrap(wrap_s[0]),
      .done(done_s[0]), .load_err(err_s[0]));
   chrono_counter #(.TICK_DIV(1), .MODE_24H(0)) u_d12 (
      .clk(clk), .rst_n(rst_n), .run(run_s[1]), .dir(dir_s[1]), .load(load_s[1]),
      .preset(pre_s[1]), .lap_hold(lap_s[1]), .time_q(tq[1]), .wrap(wrap_s[1]),
      .done(done_s[1]), .load_err(err_s[1]));
   chrono_counter #(.TICK_DIV(4), .MODE_24H(1)) u_d4 (
      .clk(clk), .rst_n(rst_n), .run(run_s[2]), .dir(dir_s[2]), .load(load_s[2]),
      .preset(pre_s[2]), .lap_hold(lap_s[2]), .time_q(tq[2]), .wrap(wrap_s[2]),
      .done(done_s[2]), .load_err(err_s[2]));

   typedef struct {
      int          id;
      string       name;
      logic        ld;
      logic        rn;
      logic        dr;
      logic [27:0] pre;
      logic [27:0] et;
      logic        ew;
      logic        ed;
      logic        ee;
   } vec_t;

   typedef struct {
      int          id;
      string       name;
      logic [27:0] et;
      logic        ew;
      logic        ed;
      logic        ee;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic logic [27:0] tv(input int h, input int m, input int s, input int c);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
              3'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic add(input int id, input string nm, input logic ld, input logic rn, input logic dr,
                      input logic [27:0] p, input logic [27:0] et, input logic ew, input logic ed,
                      input logic ee);
      vec_t v;
      v.id = id; v.name = nm; v.ld = ld; v.rn = rn; v.dr = dr; v.pre = p;
      v.et = et; v.ew = ew; v.ed = ed; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic expect_out(input int id, input string nm, input logic [27:0] et,
                             input logic ew, input logic ed, input logic ee);
      exp_t e;
      e.id = id; e.name = nm; e.et = et; e.ew = ew; e.ed = ed; e.ee = ee;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t        e;
      logic [27:0] at;
      logic        aw, ad, ae;
      n_run++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: output produced with no expectation queued");
         return;
      end
      e  = sb.pop_front();
      at = tq[e.id];
      aw = wrap_s[e.id];
      ad = done_s[e.id];
      ae = err_s[e.id];
      if ({at, aw, ad, ae} !== {e.et, e.ew, e.ed, e.ee}) begin
         n_fail++;
         $display("FAIL %s (dut%0d): got time_q=%h wrap=%b done=%b load_err=%b, want time_q=%h wrap=%b done=%b load_err=%b",
                  e.name, e.id, at, aw, ad, ae, e.et, e.ew, e.ed, e.ee);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input logic ld, input logic rn, input logic dr,
                        input logic [27:0] p);
      for (int i = 0; i < 3; i++) begin
         load_s[i] = 1'b0;
         run_s[i]  = 1'b0;
      end
      load_s[id] = ld;
      run_s[id]  = rn;
      dir_s[id]  = dr;
      pre_s[id]  = p;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [27:0] z12, bad_cs;
      z12    = tv(12, 0, 0, 0);
      bad_cs = 28'h000000A;
      rst_n  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_s[i] = 1'b0; dir_s[i] = 1'b0; load_s[i] = 1'b0; lap_s[i] = 1'b0; pre_s[i] = '0;
      end

      // 24h, TICK_DIV=1: rollover, down to zero, rejected loads, load vs tick, borrow, dir change.
      add(0, "24h load 23:59:59.98",  1, 0, 0, tv(23,59,59,98), tv(0,0,0,0),     0, 0, 0);
      add(0, "24h preset visible",    0, 1, 0, '0,              tv(23,59,59,98), 0, 0, 0);
      add(0, "24h .99",               0, 1, 0, '0,              tv(23,59,59,99), 0, 0, 0);
      add(0, "24h rollover wrap",     0, 0, 0, '0,              tv(0,0,0,0),     1, 0, 0);
      add(0, "24h wrap one cycle",    0, 0, 0, '0,              tv(0,0,0,0),     0, 0, 0);
      add(0, "dn load .02",           1, 0, 1, tv(0,0,0,2),     tv(0,0,0,0),     0, 0, 0);
      add(0, "dn .02",                0, 1, 1, '0,              tv(0,0,0,2),     0, 0, 0);
      add(0, "dn .01",                0, 1, 1, '0,              tv(0,0,0,1),     0, 0, 0);
      add(0, "dn zero done",          0, 1, 1, '0,              tv(0,0,0,0),     0, 1, 0);
      add(0, "dn saturate no done",   0, 1, 1, '0,              tv(0,0,0,0),     0, 0, 0);
      add(0, "dn held",               0, 0, 1, '0,              tv(0,0,0,0),     0, 0, 0);
      add(0, "bad md=6 load",         1, 0, 0, tv(0,60,0,0),    tv(0,0,0,0),     0, 0, 0);
      add(0, "bad md=6 load_err",     0, 0, 0, '0,              tv(0,0,0,0),     0, 0, 1);
      add(0, "bad md=6 unchanged",    0, 0, 0, '0,              tv(0,0,0,0),     0, 0, 0);
      add(0, "load+tick",             1, 1, 0, tv(1,2,3,4),     tv(0,0,0,0),     0, 0, 0);
      add(0, "load+tick no inc",      0, 0, 0, '0,              tv(1,2,3,4),     0, 0, 0);
      add(0, "load+tick stable",      0, 0, 0, '0,              tv(1,2,3,4),     0, 0, 0);
      add(0, "load 10:00 down",       1, 1, 1, tv(10,0,0,0),    tv(1,2,3,4),     0, 0, 0);
      add(0, "borrow tick",           0, 1, 1, '0,              tv(10,0,0,0),    0, 0, 0);
      add(0, "borrow 09:59:59.99",    0, 0, 1, '0,              tv(9,59,59,99),  0, 0, 0);
      add(0, "dir flip up tick",      0, 1, 0, '0,              tv(9,59,59,99),  0, 0, 0);
      add(0, "dir flip 10:00",        0, 0, 0, '0,              tv(10,0,0,0),    0, 0, 0);
      add(0, "bad hrs 24 load",       1, 0, 0, tv(24,0,0,0),    tv(10,0,0,0),    0, 0, 0);
      add(0, "bad hrs 24 load_err",   0, 0, 0, '0,              tv(10,0,0,0),    0, 0, 1);
      add(0, "bad cs=A load",         1, 0, 0, bad_cs,          tv(10,0,0,0),    0, 0, 0);
      add(0, "bad cs=A load_err",     0, 0, 0, '0,              tv(10,0,0,0),    0, 0, 1);
      // 12h, TICK_DIV=1.
      add(1, "12h load 12:59:59.99",  1, 0, 0, tv(12,59,59,99), z12,             0, 0, 0);
      add(1, "12h rollover tick",     0, 1, 0, '0,              tv(12,59,59,99), 0, 0, 0);
      add(1, "12h 01:00 wrap",        0, 0, 0, '0,              tv(1,0,0,0),     1, 0, 0);
      add(1, "12h load 11:59:59.99",  1, 0, 0, tv(11,59,59,99), tv(1,0,0,0),     0, 0, 0);
      add(1, "12h 11->12 tick",       0, 1, 0, '0,              tv(11,59,59,99), 0, 0, 0);
      add(1, "12h 12:00 no wrap",     0, 0, 0, '0,              z12,             0, 0, 0);
      add(1, "12h load 01:00",        1, 0, 0, tv(1,0,0,0),     z12,             0, 0, 0);
      add(1, "12h down from 01",      0, 1, 1, '0,              tv(1,0,0,0),     0, 0, 0);
      add(1, "12h 12:59:59.99",       0, 0, 1, '0,              tv(12,59,59,99), 0, 0, 0);
      add(1, "12h load 12:00:00.01",  1, 0, 1, tv(12,0,0,1),    tv(12,59,59,99), 0, 0, 0);
      add(1, "12h down to zero",      0, 1, 1, '0,              tv(12,0,0,1),    0, 0, 0);
      add(1, "12h zero done",         0, 1, 1, '0,              z12,             0, 1, 0);
      add(1, "12h zero held",         0, 0, 1, '0,              z12,             0, 0, 0);
      add(1, "12h bad hrs 00 load",   1, 0, 0, tv(0,0,0,0),     z12,             0, 0, 0);
      add(1, "12h bad hrs 00 err",    0, 0, 0, '0,              z12,             0, 0, 1);
      add(1, "12h load 09:59:59.99",  1, 0, 0, tv(9,59,59,99),  z12,             0, 0, 0);
      add(1, "12h 09->10 tick",       0, 1, 0, '0,              tv(9,59,59,99),  0, 0, 0);
      add(1, "12h 10:00",             0, 0, 0, '0,              tv(10,0,0,0),    0, 0, 0);

      repeat (2) step();
      expect_out(0, "reset dut24", tv(0,0,0,0), 0, 0, 0); pop_cmp();
      expect_out(1, "reset dut12", z12,         0, 0, 0); pop_cmp();
      expect_out(2, "reset dut4",  tv(0,0,0,0), 0, 0, 0); pop_cmp();
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].id, tbl[k].ld, tbl[k].rn, tbl[k].dr, tbl[k].pre);
         expect_out(tbl[k].id, tbl[k].name, tbl[k].et, tbl[k].ew, tbl[k].ed, tbl[k].ee);
         step();
         pop_cmp();
      end

      // Lap freeze on the TICK_DIV=4 instance: 40 clocks = 10 ticks behind a frozen display.
      drive(2, 1, 0, 0, tv(0,0,0,3));
      step();
      drive(2, 0, 0, 0, '0);
      expect_out(2, "lap preload .03", tv(0,0,0,3), 0, 0, 0);
      step();
      pop_cmp();
      lap_s[2] = 1'b1;
      drive(2, 0, 1, 0, '0);
      for (int i = 1; i <= 40; i++) begin
         if (i == 1 || i == 20 || i == 40) expect_out(2, "lap frozen", tv(0,0,0,3), 0, 0, 0);
         step();
         if (i == 1 || i == 20 || i == 40) pop_cmp();
      end
      lap_s[2] = 1'b0;
      drive(2, 0, 0, 0, '0);
      expect_out(2, "lap release live", tv(0,0,0,13), 0, 0, 0);
      step();
      pop_cmp();

      // Asynchronous reset in the middle of a running count.
      drive(0, 1, 0, 0, tv(5,12,30,47));
      step();
      drive(0, 0, 1, 0, '0);
      expect_out(0, "pre-reset 05:12:30.47", tv(5,12,30,47), 0, 0, 0);
      step();
      pop_cmp();
      #3;
      rst_n = 1'b0;
      #1;
      expect_out(0, "async reset dut24", tv(0,0,0,0), 0, 0, 0); pop_cmp();
      expect_out(1, "async reset dut12", z12,         0, 0, 0); pop_cmp();
      step();
      #3;
      rst_n = 1'b1;
      expect_out(0, "post-reset first tick", tv(0,0,0,0), 0, 0, 0);
      step();
      pop_cmp();
      expect_out(0, "post-reset counting", tv(0,0,0,1), 0, 0, 0);
      step();
      pop_cmp();
      drive(0, 0, 0, 0, '0);
      expect_out(0, "post-reset .02 no pulses", tv(0,0,0,2), 0, 0, 0);
      step();
      pop_cmp();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
